// File: rtl/mf_disp_fb_wr_sched_if.sv
// Frame-buffer write scheduler bus: CPU write port, fill command port,
// double-buffer swap control and the registered frame-buffer write port.
// The slave modport is the scheduler; the master modport is its environment.
interface mf_disp_fb_wr_sched_if;
    logic        cpu_wr_req;
    logic [15:0] cpu_wr_addr;
    logic [31:0] cpu_wr_data;
    logic        cpu_wr_ack;

    logic        fill_start;
    logic [15:0] fill_base;
    logic [13:0] fill_len;
    logic [7:0]  fill_color;
    logic        fill_busy;
    logic        fill_done;

    logic        swap_req;
    logic        vblank;
    logic        swap_pending;
    logic        fb_active_sel;

    logic        fb_wr_vld;
    logic [15:0] fb_wr_addr;
    logic [31:0] fb_wr_data;

    modport slave (
        input  cpu_wr_req, cpu_wr_addr, cpu_wr_data,
        input  fill_start, fill_base, fill_len, fill_color,
        input  swap_req, vblank,
        output cpu_wr_ack, fill_busy, fill_done,
        output swap_pending, fb_active_sel,
        output fb_wr_vld, fb_wr_addr, fb_wr_data
    );

    modport master (
        output cpu_wr_req, cpu_wr_addr, cpu_wr_data,
        output fill_start, fill_base, fill_len, fill_color,
        output swap_req, vblank,
        input  cpu_wr_ack, fill_busy, fill_done,
        input  swap_pending, fb_active_sel,
        input  fb_wr_vld, fb_wr_addr, fb_wr_data
    );
endinterface

// File: rtl/mf_disp_fb_wr_sched.sv
// Frame-buffer write scheduler: merges CPU word writes with an optional
// rectangle-free linear fill engine onto one registered write port, and
// executes double-buffer swaps during vertical blank.
// Build option: define MF_DISP_FILL_EN to include the fill engine and the
// CPU_MAX_RUN fairness limiter; without it the CPU owns the port outright.
module mf_disp_fb_wr_sched #(
    parameter int CPU_MAX_RUN = 4
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    mf_disp_fb_wr_sched_if.slave   bus
);

    logic        cpu_grant;
    logic        fill_grant;
    logic [15:0] fill_addr;
    logic [31:0] fill_data;
    logic        fill_busy;
    logic        fill_done;

    logic        wr_vld_q, wr_vld_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        swap_pending_q, swap_pending_d;
    logic        sel_q, sel_d;
    logic        swap_exec;

    // Address low bits are byte lanes within a word and carry no meaning here.
    logic unused_lsb;
    assign unused_lsb = ^{bus.cpu_wr_addr[1:0], bus.fill_base[1:0]};

`ifdef MF_DISP_FILL_EN
    // Wide enough to hold the value CPU_MAX_RUN itself.
    localparam int RUN_W = $clog2(CPU_MAX_RUN + 2);

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_RUN,
        FILL_DONE
    } fill_state_e;

    fill_state_e      state_q, state_d;
    logic [13:0]      word_q, word_d;
    logic [13:0]      remain_q, remain_d;
    logic [7:0]       color_q, color_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             run_limit;

    assign run_limit = (run_q == RUN_W'(CPU_MAX_RUN));
    assign fill_busy = (state_q != FILL_IDLE);
    assign fill_done = (state_q == FILL_DONE);
    assign fill_addr = {word_q, 2'b00};
    assign fill_data = {4{color_q}};

    // Arbitration and fill sequencing: CPU wins unless it has hogged the
    // port for CPU_MAX_RUN cycles while a fill is waiting.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        remain_d   = remain_q;
        color_d    = color_q;
        cpu_grant  = bus.cpu_wr_req;
        fill_grant = 1'b0;
        if (state_q == FILL_RUN) begin
            cpu_grant  = bus.cpu_wr_req && !run_limit;
            fill_grant = !cpu_grant;
        end
        case (state_q)
            FILL_IDLE: begin
                if (bus.fill_start) begin
                    word_d   = bus.fill_base[15:2];
                    remain_d = bus.fill_len;
                    color_d  = bus.fill_color;
                    state_d  = (bus.fill_len == 14'd0) ? FILL_DONE : FILL_RUN;
                end
            end
            FILL_RUN: begin
                if (fill_grant) begin
                    word_d   = word_q + 14'd1;
                    remain_d = remain_q - 14'd1;
                    if (remain_q == 14'd1) begin
                        state_d = FILL_DONE;
                    end
                end
            end
            FILL_DONE: state_d = FILL_IDLE;
            default:   state_d = FILL_IDLE;
        endcase
    end

    // Consecutive-CPU-grant counter; saturates so it never exceeds the limit.
    always_comb begin
        run_d = '0;
        if (cpu_grant) begin
            run_d = run_limit ? run_q : run_q + RUN_W'(1);
        end
    end

    // Fill state, captured command and fairness counter.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q  <= FILL_IDLE;
            word_q   <= '0;
            remain_q <= '0;
            color_q  <= '0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            remain_q <= remain_d;
            color_q  <= color_d;
            run_q    <= run_d;
        end
    end
`else
    localparam int unused_max_run = CPU_MAX_RUN;

    logic unused_fill;
    assign unused_fill = ^{bus.fill_start, bus.fill_base[15:2], bus.fill_len, bus.fill_color};

    assign cpu_grant  = bus.cpu_wr_req;
    assign fill_grant = 1'b0;
    assign fill_busy  = 1'b0;
    assign fill_done  = 1'b0;
    assign fill_addr  = '0;
    assign fill_data  = '0;
`endif

    // Write-port mux: addr/data hold their last value when nothing is granted.
    always_comb begin
        wr_vld_d  = cpu_grant | fill_grant;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (cpu_grant) begin
            wr_addr_d = {bus.cpu_wr_addr[15:2], 2'b00};
            wr_data_d = bus.cpu_wr_data;
        end else if (fill_grant) begin
            wr_addr_d = fill_addr;
            wr_data_d = fill_data;
        end
    end

    // Swap runs only in blanking with no fill in flight; a request arriving
    // on the execute cycle is kept for the following blank.
    always_comb begin
        swap_exec      = swap_pending_q && bus.vblank && !fill_busy;
        swap_pending_d = swap_exec ? bus.swap_req : (swap_pending_q | bus.swap_req);
        sel_d          = sel_q ^ swap_exec;
    end

    // Registered write port and buffer-select state.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_vld_q       <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            swap_pending_q <= 1'b0;
            sel_q          <= 1'b0;
        end else begin
            wr_vld_q       <= wr_vld_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            swap_pending_q <= swap_pending_d;
            sel_q          <= sel_d;
        end
    end

    assign bus.cpu_wr_ack    = cpu_grant;
    assign bus.fill_busy     = fill_busy;
    assign bus.fill_done     = fill_done;
    assign bus.swap_pending  = swap_pending_q;
    assign bus.fb_active_sel = sel_q;
    assign bus.fb_wr_vld     = wr_vld_q;
    assign bus.fb_wr_addr    = wr_addr_q;
    assign bus.fb_wr_data    = wr_data_q;

endmodule
